// File: rtl/step_pkg.sv
// Shared types and default timing constants for the push-button step pulse generator.
package step_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_HELD,
        ST_REPEAT,
        ST_RELEASE_DB
    } step_state_t;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEF_REPEAT_DELAY    = 500000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 100000;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/step_pulse_gen_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous bit; clears to 0 on reset.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/step_pulse_gen.sv
// Push-button front end: synchronise, debounce press/release, emit single-cycle step pulses
// with optional auto-repeat while the button is held.
module step_pulse_gen
    import step_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_in,
    input  logic repeat_en,
    output logic step,
    output logic pressed,
    output logic repeating
);

    localparam int unsigned TW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [TW-1:0] ONE     = TW'(1);
    localparam logic [TW-1:0] DB_DONE = TW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RP_LAST = TW'(REPEAT_PERIOD - 1);

    logic        btn_s;
    step_state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        step_q, step_d;
    logic        pressed_q, pressed_d;
    logic        repeating_q, repeating_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i (clock),
        .rst_i (reset),
        .d_i   (btn_in),
        .q_o   (btn_s)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        step_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (btn_s) begin
                    state_d = ST_PRESS_DB;
                    timer_d = ONE;
                end
            end
            ST_PRESS_DB: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q >= DB_DONE) begin
                    state_d = ST_HELD;
                    timer_d = '0;
                    step_d  = 1'b1;
                end else begin
                    timer_d = timer_q + ONE;
                end
            end
            ST_HELD: begin
                // Release takes priority over a coincident repeat event.
                if (!btn_s) begin
                    state_d = ST_RELEASE_DB;
                    timer_d = ONE;
                end else if (repeat_en && timer_q == RD_LAST) begin
                    state_d = ST_REPEAT;
                    timer_d = '0;
                    step_d  = 1'b1;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + ONE;
                end
            end
            ST_REPEAT: begin
                if (!btn_s) begin
                    state_d = ST_RELEASE_DB;
                    timer_d = ONE;
                end else if (!repeat_en) begin
                    state_d = ST_HELD;
                    timer_d = '0;
                end else if (timer_q == RP_LAST) begin
                    timer_d = '0;
                    step_d  = 1'b1;
                end else begin
                    timer_d = timer_q + ONE;
                end
            end
            ST_RELEASE_DB: begin
                if (btn_s) begin
                    state_d = ST_HELD;
                    timer_d = '0;
                end else if (timer_q >= DB_DONE) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
        pressed_d   = (state_d == ST_HELD) || (state_d == ST_REPEAT) ||
                      (state_d == ST_RELEASE_DB);
        repeating_d = (state_d == ST_REPEAT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            step_q      <= 1'b0;
            pressed_q   <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            step_q      <= step_d;
            pressed_q   <= pressed_d;
            repeating_q <= repeating_d;
        end
    end

    assign step      = step_q;
    assign pressed   = pressed_q;
    assign repeating = repeating_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: event/timestamp reference model plus directed scenarios.
module tb_step_pulse_gen;

    localparam int S     = 2;
    localparam int D     = 4;
    localparam int RD    = 8;
    localparam int RP    = 3;
    localparam int DEPTH = 4096;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic btn_in = 1'b0;
    logic repeat_en = 1'b0;
    logic step, pressed, repeating;

    int checks = 0;
    int failures = 0;

    step_pulse_gen #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_in    (btn_in),
        .repeat_en (repeat_en),
        .step      (step),
        .pressed   (pressed),
        .repeating (repeating)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: btn_s is btn_in as sampled S edges earlier; a level change is accepted
    // once D+1 consecutive edges agree; repeats are timestamps relative to hold/repeat start.
    int   now, run, hold_t, rep_t;
    logic bs, prev_bs, changed;
    logic m_pressed, m_rep, m_step;
    logic samp [DEPTH];

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                now = 0; run = 0; hold_t = 0; rep_t = 0;
                prev_bs = 1'b0; m_pressed = 1'b0; m_rep = 1'b0; m_step = 1'b0;
            end else begin
                bs = (now >= S) ? samp[(now - S) % DEPTH] : 1'b0;
                samp[now % DEPTH] = btn_in;
                changed = (bs != prev_bs);
                run = changed ? 1 : run + 1;
                prev_bs = bs;
                m_step = 1'b0;
                if (!m_pressed) begin
                    if (bs && run == D + 1) begin
                        m_pressed = 1'b1; m_rep = 1'b0; hold_t = now; m_step = 1'b1;
                    end
                end else if (!bs) begin
                    m_rep = 1'b0;
                    if (run == D + 1) m_pressed = 1'b0;
                end else if (changed) begin
                    hold_t = now;
                end else if (!m_rep) begin
                    if (repeat_en && (now - hold_t) == RD) begin
                        m_rep = 1'b1; rep_t = now; m_step = 1'b1;
                    end
                end else if (!repeat_en) begin
                    m_rep = 1'b0; hold_t = now;
                end else if (((now - rep_t) % RP) == 0) begin
                    m_step = 1'b1;
                end
                now++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk("model_step", step, m_step);
                chk("model_pressed", pressed, m_pressed);
                chk("model_repeating", repeating, m_rep);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_step", step, 1'b0);
        chk("rst_pressed", pressed, 1'b0);
        chk("rst_repeating", repeating, 1'b0);
        reset = 1'b0;
        tick(); tick();

        // Clean press, no repeat: single step after edge 6.
        btn_in = 1'b1; repeat_en = 1'b0;
        for (int e = 0; e <= 56; e++) begin
            tick();
            chk("t1_step", step, e == 6);
            chk("t1_pressed", pressed, e >= 6);
        end

        // Clean release: pressed falls after edge r+6.
        btn_in = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            tick();
            chk("t4_rel_pressed", pressed, e < 6);
            chk("t4_rel_step", step, 1'b0);
        end

        // Press bounce: 3 high / 2 low never reaches the debounce count.
        for (int b = 0; b < 4; b++) begin
            btn_in = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("t2_step", step, 1'b0);
                chk("t2_pressed", pressed, 1'b0);
            end
            btn_in = 1'b0;
            for (int i = 0; i < 2; i++) begin
                tick();
                chk("t2_step", step, 1'b0);
                chk("t2_pressed", pressed, 1'b0);
            end
        end
        repeat (8) tick();

        // Auto-repeat: steps after edges 6,14,17,20,23.
        btn_in = 1'b1; repeat_en = 1'b1;
        for (int e = 0; e <= 25; e++) begin
            tick();
            chk("t3_step", step, (e == 6) || (e == 14) || (e == 17) || (e == 20) || (e == 23));
            chk("t3_repeating", repeating, e >= 14);
        end

        // repeat_en dropped in REPEAT: back to held, no further steps.
        repeat_en = 1'b0;
        for (int e = 0; e < 40; e++) begin
            tick();
            chk("t6_repeating", repeating, 1'b0);
            chk("t6_step", step, 1'b0);
            chk("t6_pressed", pressed, 1'b1);
        end

        // Two-cycle release glitch returns to held with no extra step.
        btn_in = 1'b0;
        tick(); tick();
        btn_in = 1'b1;
        for (int e = 0; e < 15; e++) begin
            tick();
            chk("t4_glitch_pressed", pressed, 1'b1);
            chk("t4_glitch_step", step, 1'b0);
        end

        btn_in = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            tick();
            chk("t6_rel_pressed", pressed, e < 6);
        end

        // Reset mid-repeat with the button still held.
        btn_in = 1'b1; repeat_en = 1'b1;
        for (int e = 0; e <= 15; e++) tick();
        chk("t5_pre_repeating", repeating, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_step", step, 1'b0);
        chk("t5_async_pressed", pressed, 1'b0);
        chk("t5_async_repeating", repeating, 1'b0);
        repeat_en = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int e = 0; e < 30; e++) begin
            tick();
            chk("t5_step", step, e == 6);
            chk("t5_pressed", pressed, e >= 6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
